// File: rtl/delay_sequencer.sv
// delay_sequencer: issues start pulses to the countdown delay block, counts
// its completion pulses over STEPS rounds and reports the end of the
// sequence. A per-round watchdog flags a delay block that never answers.
module delay_sequencer #(
  parameter int unsigned     STEPS   = 4,
  parameter int unsigned     TO_W    = 25,
  parameter logic [TO_W-1:0] TIMEOUT = 25'd20000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       done_in,
  output logic       start_out,
  output logic       busy,
  output logic       step_done,
  output logic       seq_done,
  output logic       timeout_err,
  output logic [7:0] step_idx
);

  typedef enum logic [1:0] {IDLE, FIRE, WAIT, ERR} state_t;

  localparam logic [7:0]      LAST_STEP = 8'(STEPS);
  // Watchdog value seen in the final WAIT cycle a round is allowed.
  localparam logic [TO_W-1:0] WD_LAST   = TIMEOUT - TO_W'(1);

  state_t          state, state_nx;
  logic [TO_W-1:0] watchdog, watchdog_nx;
  logic            done_q;
  logic            done_edge;
  logic            start_nx, busy_nx, step_done_nx, seq_done_nx, err_nx;
  logic [7:0]      step_idx_nx;

  // A done pulse of any length yields one edge, and a level already high
  // when a round starts is ignored until it has been seen low.
  assign done_edge = done_in & ~done_q;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    // NOTE: every signal gets its hold/idle value first so no path through
    // the case leaves one unassigned, which would infer a latch.
    state_nx     = state;
    watchdog_nx  = watchdog;
    step_idx_nx  = step_idx;
    err_nx       = timeout_err;
    step_done_nx = 1'b0;
    seq_done_nx  = 1'b0;

    case (state)
      IDLE, ERR: begin
        if (go) begin
          step_idx_nx = 8'd0;
          err_nx      = 1'b0;
          state_nx    = FIRE;
        end
      end
      FIRE: begin
        watchdog_nx = '0;
        state_nx    = WAIT;
      end
      WAIT: begin
        watchdog_nx = watchdog + TO_W'(1);
        // The edge is tested first so an answer in the expiry cycle wins.
        if (done_edge) begin
          step_done_nx = 1'b1;
          step_idx_nx  = step_idx + 8'd1;
          if (step_idx + 8'd1 == LAST_STEP) begin
            seq_done_nx = 1'b1;
            state_nx    = IDLE;
          end else begin
            state_nx = FIRE;
          end
        end else if (watchdog == WD_LAST) begin
          err_nx   = 1'b1;
          state_nx = ERR;
        end
      end
    endcase

    // Outputs follow the state being entered, so they appear together with
    // it after the clock edge.
    start_nx = (state_nx == FIRE);
    busy_nx  = (state_nx == FIRE) || (state_nx == WAIT);
  end

  // State, watchdog, done history and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state       <= IDLE;
      watchdog    <= '0;
      done_q      <= 1'b0;
      start_out   <= 1'b0;
      busy        <= 1'b0;
      step_done   <= 1'b0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
      step_idx    <= 8'd0;
    end else begin
      state       <= state_nx;
      watchdog    <= watchdog_nx;
      done_q      <= done_in;
      start_out   <= start_nx;
      busy        <= busy_nx;
      step_done   <= step_done_nx;
      seq_done    <= seq_done_nx;
      timeout_err <= err_nx;
      step_idx    <= step_idx_nx;
    end
  end

endmodule

// File: tb/tb_delay_sequencer.sv
// Bench for delay_sequencer: a stimulus plan (go, rst, done_in per clock
// edge) is built up front together with the expected output changes, which
// a monitor compares against the outputs the DUT presents.
module tb_delay_sequencer;

  localparam int unsigned     STEPS   = 3;
  localparam int unsigned     TO_W    = 8;
  localparam logic [TO_W-1:0] TIMEOUT = 8'd16;
  localparam int              T       = 16;
  localparam int              N       = 4000;
  localparam int              NDIR    = 11;

  logic       clk;
  logic       rst;
  logic       go;
  logic       done_in;
  logic       start_out;
  logic       busy;
  logic       step_done;
  logic       seq_done;
  logic       timeout_err;
  logic [7:0] step_idx;

  delay_sequencer #(
    .STEPS  (STEPS),
    .TO_W   (TO_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .done_in    (done_in),
    .start_out  (start_out),
    .busy       (busy),
    .step_done  (step_done),
    .seq_done   (seq_done),
    .timeout_err(timeout_err),
    .step_idx   (step_idx)
  );

  // Output vector layout: start, busy, step_done, seq_done, timeout_err, idx.
  typedef struct {
    int          cyc;
    logic [12:0] v;
  } ev_t;

  ev_t exp_q[$];
  bit  go_a[N];
  bit  rst_a[N];
  bit  done_a[N];
  int  checks = 0;
  int  errors = 0;

  // Directed delay-block answers for the first rounds: three nominal rounds,
  // a nominal then a silent round, an answer in the watchdog expiry cycle,
  // a 4-cycle pulse, a pulse overlapping the last round into IDLE, and a
  // pulse held across the next FIRE followed by a fresh one.
  int dir_d[NDIR] = '{6, 6, 6, 6, 0, T + 1, 6, 2, 2, 10, 6};
  int dir_l[NDIR] = '{2, 2, 2, 2, 0, 2,     4, 8, 8, 2,  2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic put_pulse(input int from, input int len);
    for (int i = 0; i < len; i++)
      if (from + i < N) done_a[from + i] = 1'b1;
  endtask

  // Delay-block answer to a start pulse first seen high after edge c.
  task automatic respond(input int c, input int k);
    if (k < NDIR) begin
      if (dir_d[k] != 0) put_pulse(c + dir_d[k], dir_l[k]);
    end else if ($urandom_range(0, 9) != 0) begin
      put_pulse(c + $urandom_range(2, T + 3), $urandom_range(1, 5));
    end
  endtask

  // Reference: a sequence is "active" from the accepted go; a round that
  // started at edge f may be answered by a fresh done rising edge sampled at
  // edges f+2 .. f+T+1, and with no answer by edge f+T+1 the error is raised.
  task automatic build_plan();
    bit          active = 1'b0;
    bit          err = 1'b0;
    bit          prev_done = 1'b0;
    bit          rst_done = 1'b0;
    bit          st, sd, sq;
    int          fire = 0;
    int          idx = 0;
    int          resp_no = 0;
    logic [12:0] pv = 'x;
    logic [12:0] v;
    for (int c = 0; c < N; c++) begin
      if (c < 3) rst_a[c] = 1'b1;
      if (resp_no >= NDIR && $urandom_range(0, 499) == 0) rst_a[c] = 1'b1;
      if (c >= 3) go_a[c] = (c >= 2000 && c < 2600) || ($urandom_range(0, 3) == 0);
      st = 1'b0;
      sd = 1'b0;
      sq = 1'b0;
      if (rst_a[c]) begin
        active = 1'b0;
        err    = 1'b0;
        idx    = 0;
      end else if (!active) begin
        if (go_a[c]) begin
          active = 1'b1;
          err    = 1'b0;
          idx    = 0;
          fire   = c;
          st     = 1'b1;
          respond(c, resp_no);
          resp_no++;
        end else if (resp_no >= NDIR && $urandom_range(0, 19) == 0) begin
          put_pulse(c + 1, $urandom_range(1, 3));
        end
      end else if (c > fire + 1) begin
        if (done_a[c] && !prev_done) begin
          sd = 1'b1;
          idx++;
          if (idx == int'(STEPS)) begin
            sq     = 1'b1;
            active = 1'b0;
          end else begin
            fire = c;
            st   = 1'b1;
            respond(c, resp_no);
            resp_no++;
          end
        end else if (c - fire == T + 1) begin
          err    = 1'b1;
          active = 1'b0;
        end
        // One reset planted while waiting on the second round.
        if (active && !rst_done && resp_no >= NDIR && idx == 1 && c > fire + 1 && c + 1 < N) begin
          rst_a[c + 1] = 1'b1;
          rst_done     = 1'b1;
        end
      end
      prev_done = rst_a[c] ? 1'b0 : done_a[c];
      v = {st, active, sd, sq, err, 8'(idx)};
      if (rst_a[c] || v !== pv) exp_q.push_back('{c, v});
      pv = v;
    end
  endtask

  task automatic drive(input int c);
    rst     = rst_a[c];
    go      = go_a[c];
    done_in = done_a[c];
  endtask

  initial begin
    build_plan();
    drive(0);
    fork
      begin : driver
        for (int c = 0; c < N; c++) begin
          @(posedge clk);
          #2;
          if (c + 1 < N) drive(c + 1);
        end
      end
      begin : monitor
        logic [12:0] dprev = 'x;
        logic [12:0] dv;
        ev_t         e;
        for (int mc = 0; mc < N; mc++) begin
          @(posedge clk);
          #4;
          dv = {start_out, busy, step_done, seq_done, timeout_err, step_idx};
          while (exp_q.size() > 0 && exp_q[0].cyc < mc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event cyc=%0d got=%h expected=%h at cyc=%0d",
                     mc, dv, e.v, e.cyc);
          end
          if (exp_q.size() > 0 && exp_q[0].cyc == mc) begin
            e = exp_q.pop_front();
            checks++;
            if (dv !== e.v) begin
              errors++;
              $display("FAIL outputs cyc=%0d got=%h expected=%h (start,busy,step_done,seq_done,timeout_err,step_idx[7:0])",
                       mc, dv, e.v);
            end
          end else if (dv !== dprev) begin
            checks++;
            errors++;
            $display("FAIL unexpected_change cyc=%0d got=%h previous=%h", mc, dv, dprev);
          end
          dprev = dv;
        end
      end
    join
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
